control_unit: RTL
=================

# control_unit

Hard-wired Moore control unit that sequences the existing single-bus datapath through fetch and execute. Each control step lasts exactly one `clock` cycle. In each step it drives the bus-encoder one-hot select, the register enables, the ALU function, memory read/write, PC increment and the Gra/Grb/Grc/Rin/Rout/BAout select-and-encode strobes. It replaces hand-timed stimulus with a per-opcode step sequence. It sits beside `datapath`, consuming the IR contents and the CON flip-flop output.

## Interface
Parameters:
- `OP_HI`, default 31: MSB of the opcode field in `ir`. The opcode is `ir[OP_HI:OP_HI-4]`.

Ports:
- `clock`  in  1  rising-edge clock.
- `clr`  in  1  asynchronous, active-low reset.
- `ir`  in  32  IR register contents.
- `con_ff`  in  1  CONFFOut from the datapath.
- `enc_sel`  out  32  one-hot bus-source select. Bit indices: 16 HI, 17 LO, 19 Zlow, 20 PC, 21 IR, 22 MDR, 23 MAR, 24 Y, 25 C (sign-extended constant), 26 in-port.
- `reg_en`  out  32  register load enables. Uses the same indices as `enc_sel`; bit 19 is Zin.
- `alu_sel`  out  6  ALU function code.
- `read`, `write`  out  1 each  memory strobes.
- `inc_pc`  out  1  PC increment.
- `gra`, `grb`, `grc`, `rin`, `rout`, `ba_out`  out  1 each  register-file select/encode strobes.
- `con_in`  out  1  CON flip-flop load.
- `outport_en`  out  1  out-port load.
- `run`  out  1  high unless in HALT.
- `illegal`  out  1  one-cycle pulse on an undefined opcode.
- `step`  out  3  current step number T0..T7 (debug).

## Operation
States: RST, T0–T7, HALT. State is held in a register. All outputs are decoded combinationally from the state and `ir[31:27]`. Any output not listed for a step is 0.

Fetch, common to all instructions:
- T0: `enc_sel[20]`, `reg_en[23]`, `inc_pc`.
- T1: `read`, `reg_en[22]`.
- T2: `enc_sel[22]`, `reg_en[21]`.
- `ir` is valid from T3 onward and is decoded directly.

Opcodes, with `alu_sel` = `{1'b0,opcode}` for ALU classes:
- R-type (`add` 00011, `sub` 00100, `and` 00101, `or` 00110):
  - T3: `grb` `rout` `reg_en[24]`.
  - T4: `grc` `rout` `alu_sel` `reg_en[19]`.
  - T5: `enc_sel[19]` `gra` `rin`.
- Immediate (`addi` 01100, `andi` 01101, `ori` 01110): same as R-type, except T4 drives `enc_sel[25]` instead of `grc rout`.
- Address steps, shared by `ldi` 00001, `ld` 00000 and `st` 00010:
  - T3: `grb` `ba_out` `reg_en[24]`.
  - T4: `enc_sel[25]`, `alu_sel`=000011, `reg_en[19]`.
- `ldi`, after the address steps:
  - T5: `enc_sel[19]` `gra` `rin`.
- `ld`, after the address steps:
  - T5: `enc_sel[19]` `reg_en[23]`.
  - T6: `read` `reg_en[22]`.
  - T7: `enc_sel[22]` `gra` `rin`.
- `st`, after the address steps:
  - T5: as `ld`.
  - T6: `gra` `rout` `reg_en[22]`.
  - T7: `write`.
- `br` 10010:
  - T3: `gra` `rout` `con_in`.
  - T4: `enc_sel[20]` `reg_en[24]`.
  - T5: `enc_sel[25]`, `alu_sel`=000011, `reg_en[19]`.
  - T6: only if `con_ff`=1, `enc_sel[19]` `reg_en[20]`; otherwise no outputs.
- `jr` 10100, T3: `gra` `rout` `reg_en[20]`.
- `in` 10110, T3: `enc_sel[26]` `gra` `rin`.
- `out` 10111, T3: `gra` `rout` `outport_en`.
- `nop` 11010, T3: no outputs.
- `halt` 11011: enter HALT from T3. In HALT all outputs are 0 and `run`=0. HALT is left only by `clr`.
- Any other opcode: T3 asserts `illegal`; the instruction then behaves as `nop`.

## Timing
- Reset: `clr`=0 forces RST asynchronously. In RST all outputs are 0, `run`=1 and `step`=0. On the first rising edge after `clr` rises, the state goes RST→T0.
- Every step lasts one cycle. Registers enabled in Tn capture on the rising edge that ends Tn.
- The last step of each instruction returns to T0 on the next edge.
- Instruction lengths:
  - R-type, immediate and `ldi`: 6 cycles.
  - `ld` and `st`: 8 cycles.
  - `br`: 7 cycles, taken or not taken.
  - `jr`, `in`, `out`, `nop` and illegal: 4 cycles.
- `con_ff` is sampled only in T6 of `br`. It reflects the `con_in` load made at the end of T3.
- `enc_sel` never has more than one bit set in any state. This is checked by assertion.
- `read` and `write` are never high together.
- `clr` asserted in any state, including mid-`st` T7 or HALT, returns to RST within the same cycle and deasserts all outputs immediately. Memory write is not guaranteed.

## Test plan
- Reset then fetch: release `clr`. The bench sees RST for 1 cycle, then T0 with `enc_sel`=0x0010_0000, `reg_en`=0x0080_0000 and `inc_pc`=1. T1 has `read`=1 and `reg_en`=0x0040_0000. T2 has `enc_sel`=0x0040_0000 and `reg_en`=0x0020_0000.
- `add` (`ir`=0x1891_8000): T4 shows `alu_sel`=000011 with `grc` and `rout`. T5 shows `enc_sel[19]`, `gra` and `rin`. The next state is T0 six cycles after the first T0.
- `ld` vs `st` (`ir`=0x0080_0005 and 0x1080_0005): check the T5–T7 sequences as specified. `write` pulses for exactly one cycle in `st` T7 only. An 8-cycle period is required.
- `br` with `con_ff`=1 then 0: T6 shows `reg_en[20]`=1 when taken and all outputs 0 when not taken. Both cases take 7 cycles.
- `halt` (`ir`=0xD800_0000): after T3, `run`=0 and all outputs stay 0 for 20 cycles. A `clr` pulse restarts at RST→T0.
- Illegal opcode 11111: `illegal`=1 for exactly one cycle in T3, then T0. Asserting `clr` mid-T6 of `ld` deasserts all outputs asynchronously.

Source files
------------

// File: rtl/control_unit.sv
// Hard-wired Moore sequencer for the single-bus datapath: fetch T0-T2, then
// per-opcode execute steps; every output is decoded from the step and the opcode.
module control_unit #(
  parameter int OP_HI = 31
) (
  input  logic        clock,
  input  logic        clr,
  input  logic [31:0] ir,
  input  logic        con_ff,
  output logic [31:0] enc_sel,
  output logic [31:0] reg_en,
  output logic [5:0]  alu_sel,
  output logic        read,
  output logic        write,
  output logic        inc_pc,
  output logic        gra,
  output logic        grb,
  output logic        grc,
  output logic        rin,
  output logic        rout,
  output logic        ba_out,
  output logic        con_in,
  output logic        outport_en,
  output logic        run,
  output logic        illegal,
  output logic [2:0]  step
);
  localparam logic [4:0] OP_LD   = 5'b00000, OP_LDI = 5'b00001, OP_ST   = 5'b00010;
  localparam logic [4:0] OP_ADD  = 5'b00011, OP_SUB = 5'b00100, OP_AND  = 5'b00101;
  localparam logic [4:0] OP_OR   = 5'b00110, OP_ADDI = 5'b01100, OP_ANDI = 5'b01101;
  localparam logic [4:0] OP_ORI  = 5'b01110, OP_BR  = 5'b10010, OP_JR   = 5'b10100;
  localparam logic [4:0] OP_IN   = 5'b10110, OP_OUT = 5'b10111, OP_NOP  = 5'b11010;
  localparam logic [4:0] OP_HALT = 5'b11011;

  typedef enum logic [3:0] {
    S_RST, S_T0, S_T1, S_T2, S_T3, S_T4, S_T5, S_T6, S_T7, S_HALT
  } state_t;

  state_t     state;
  logic [4:0] opc;
  logic       is_alu, is_imm, is_ldi, is_ld, is_st, is_addr, is_br;
  logic       is_jr, is_in, is_out, is_nop, is_halt, is_short;
  logic       unused_ir;

  assign opc       = ir[OP_HI -: 5];
  assign unused_ir = ^ir;
  assign is_alu    = opc inside {OP_ADD, OP_SUB, OP_AND, OP_OR};
  assign is_imm    = opc inside {OP_ADDI, OP_ANDI, OP_ORI};
  assign is_ldi    = (opc == OP_LDI);
  assign is_ld     = (opc == OP_LD);
  assign is_st     = (opc == OP_ST);
  assign is_addr   = is_ldi | is_ld | is_st;
  assign is_br     = (opc == OP_BR);
  assign is_jr     = (opc == OP_JR);
  assign is_in     = (opc == OP_IN);
  assign is_out    = (opc == OP_OUT);
  assign is_nop    = (opc == OP_NOP);
  assign is_halt   = (opc == OP_HALT);
  // jr/in/out/nop and undefined opcodes all finish in T3
  assign is_short  = !(is_alu | is_imm | is_addr | is_br | is_halt);

  always_ff @(posedge clock or negedge clr) begin
    if (!clr) state <= S_RST;
    else begin
      case (state)
        S_RST:  state <= S_T0;
        S_T0:   state <= S_T1;
        S_T1:   state <= S_T2;
        S_T2:   state <= S_T3;
        S_T3:   state <= is_halt ? S_HALT : (is_short ? S_T0 : S_T4);
        S_T4:   state <= S_T5;
        S_T5:   state <= (is_ld | is_st | is_br) ? S_T6 : S_T0;
        S_T6:   state <= is_br ? S_T0 : S_T7;
        S_T7:   state <= S_T0;
        S_HALT: state <= S_HALT;
        default: state <= S_RST;
      endcase
    end
  end

  always_comb begin
    enc_sel = '0; reg_en = '0; alu_sel = '0;
    read = 1'b0; write = 1'b0; inc_pc = 1'b0;
    gra = 1'b0; grb = 1'b0; grc = 1'b0; rin = 1'b0; rout = 1'b0; ba_out = 1'b0;
    con_in = 1'b0; outport_en = 1'b0; illegal = 1'b0;
    run  = (state != S_HALT);
    step = 3'd0;
    case (state)
      S_T0: begin step = 3'd0; enc_sel[20] = 1'b1; reg_en[23] = 1'b1; inc_pc = 1'b1; end
      S_T1: begin step = 3'd1; read = 1'b1; reg_en[22] = 1'b1; end
      S_T2: begin step = 3'd2; enc_sel[22] = 1'b1; reg_en[21] = 1'b1; end
      S_T3: begin
        step = 3'd3;
        if (is_alu | is_imm)  begin grb = 1'b1; rout = 1'b1; reg_en[24] = 1'b1; end
        else if (is_addr)     begin grb = 1'b1; ba_out = 1'b1; reg_en[24] = 1'b1; end
        else if (is_br)       begin gra = 1'b1; rout = 1'b1; con_in = 1'b1; end
        else if (is_jr)       begin gra = 1'b1; rout = 1'b1; reg_en[20] = 1'b1; end
        else if (is_in)       begin enc_sel[26] = 1'b1; gra = 1'b1; rin = 1'b1; end
        else if (is_out)      begin gra = 1'b1; rout = 1'b1; outport_en = 1'b1; end
        else if (!is_nop && !is_halt) illegal = 1'b1;
      end
      S_T4: begin
        step = 3'd4;
        if (is_alu | is_imm) begin
          alu_sel = {1'b0, opc}; reg_en[19] = 1'b1;
          if (is_imm) enc_sel[25] = 1'b1;
          else begin grc = 1'b1; rout = 1'b1; end
        end else if (is_addr) begin
          enc_sel[25] = 1'b1; alu_sel = 6'd3; reg_en[19] = 1'b1;
        end else if (is_br) begin
          enc_sel[20] = 1'b1; reg_en[24] = 1'b1;
        end
      end
      S_T5: begin
        step = 3'd5;
        if (is_alu | is_imm | is_ldi) begin enc_sel[19] = 1'b1; gra = 1'b1; rin = 1'b1; end
        else if (is_ld | is_st)       begin enc_sel[19] = 1'b1; reg_en[23] = 1'b1; end
        else if (is_br) begin enc_sel[25] = 1'b1; alu_sel = 6'd3; reg_en[19] = 1'b1; end
      end
      S_T6: begin
        step = 3'd6;
        if (is_ld)                begin read = 1'b1; reg_en[22] = 1'b1; end
        else if (is_st)           begin gra = 1'b1; rout = 1'b1; reg_en[22] = 1'b1; end
        else if (is_br && con_ff) begin enc_sel[19] = 1'b1; reg_en[20] = 1'b1; end
      end
      S_T7: begin
        step = 3'd7;
        if (is_ld)      begin enc_sel[22] = 1'b1; gra = 1'b1; rin = 1'b1; end
        else if (is_st) write = 1'b1;
      end
      default: ;
    endcase
  end

  a_enc_onehot: assert property (@(posedge clock) disable iff (!clr) $onehot0(enc_sel));
  a_rd_wr_excl: assert property (@(posedge clock) disable iff (!clr) !(read && write));
endmodule
